mood_engine: RTL and testbench

- Parametrised successor to the fixed three-drive mood datapath: NUM_CH saturating drive channels, each with a 2-bit range class.
- Adds a four-state sleep controller, a stress-driven heartbeat prescaler, and a synchronous level-load port.
- Runs on the system clock and advances only on a one-cycle tick strobe, so there are no derived clocks.
- Sits between the stimulus/regulator logic and the emotion/output mapping.

---
 rtl/mood_pkg.sv | 34 +++
 rtl/mood_channel.sv | 51 +++++
 rtl/mood_engine.sv | 159 +++++++++++++++
 tb/tb_mood_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mood_pkg.sv
// mood_pkg: shared types and helpers for the mood engine.
//   sleep_state_t : sleep controller state encoding (AWAKE/DROWSY/ASLEEP/WAKING)
//   CLS_*         : 2-bit range class codes taken from the top two level bits
//   hb_period_m1  : heartbeat period (minus one) in ticks for a stress class
package mood_pkg;

  typedef enum logic [1:0] {
    AWAKE  = 2'b00,
    DROWSY = 2'b01,
    ASLEEP = 2'b10,
    WAKING = 2'b11
  } sleep_state_t;

  localparam logic [1:0] CLS_LOW  = 2'd0;
  localparam logic [1:0] CLS_MID  = 2'd1;
  localparam logic [1:0] CLS_HIGH = 2'd2;
  localparam logic [1:0] CLS_MAX  = 2'd3;

  // Period 8/4/2/1 ticks for stress class 0/1/2/3; sleeping forces 8.
  // Returned as period-1 so the counter compare is a plain >=.
  function automatic logic [2:0] hb_period_m1(input logic [1:0] s_cls,
                                               input logic       sleeping);
    logic [2:0] m1;
    case (s_cls)
      CLS_LOW:  m1 = 3'd7;
      CLS_MID:  m1 = 3'd3;
      CLS_HIGH: m1 = 3'd1;
      default:  m1 = 3'd0;
    endcase
    if (sleeping) m1 = 3'd7;
    return m1;
  endfunction

endpackage

// File: rtl/mood_channel.sv
// mood_channel: one saturating drive channel.
//   Holds a W-bit level that steps +1/-1 on tick (saturating at 2^W-1 / 0),
//   can be overwritten by a synchronous load regardless of tick, and exposes
//   its 2-bit range class (the top two level bits).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (level -> DEFAULT_VAL)
//   tick            : model step strobe
//   inc, dec        : effective step requests (both or neither = hold)
//   load, load_val  : synchronous level load, overrides the tick update
//   level           : registered level
//   level_class     : level[W-1:W-2]
module mood_channel
  import mood_pkg::*;
#(
  parameter int             W           = 7,
  parameter logic [W-1:0]   DEFAULT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] level,
  output logic [1:0]   level_class
);

  logic [W-1:0] level_p0;

  function automatic logic [W-1:0] sat_step(input logic [W-1:0] cur,
                                            input logic         up,
                                            input logic         dn);
    logic [W-1:0] nxt;
    nxt = cur;
    if (up && !dn && (cur != '1))      nxt = cur + W'(1);
    else if (dn && !up && (cur != '0)) nxt = cur - W'(1);
    return nxt;
  endfunction

  // Stage p0: level register
  always_ff @(posedge clk) begin
    if (!rst_n)    level_p0 <= DEFAULT_VAL;
    else if (load) level_p0 <= load_val;
    else if (tick) level_p0 <= sat_step(level_p0, inc, dec);
  end

  assign level       = level_p0;
  assign level_class = level_p0[W-1 -: 2];

endmodule

// File: rtl/mood_engine.sv
// mood_engine: NUM_CH saturating drive channels plus a four-state sleep
// controller and a stress-driven heartbeat, all advancing on the tick strobe.
// Optional feature: define MOOD_WAKE_EN to add the wake_req input, which on a
// tick forces DROWSY->AWAKE and ASLEEP->WAKING ahead of other transitions.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   tick                : model step strobe, one clk wide
//   inc_req, dec_req    : per-channel external step requests
//   load, load_ch,
//   load_val            : synchronous level load (out-of-range load_ch ignored)
//   wake_req            : (MOOD_WAKE_EN only) wake request
//   level               : packed registered levels, slice i = channel i
//   level_class         : packed 2-bit classes, slice i = channel i
//   sleep_state         : 00 AWAKE, 01 DROWSY, 10 ASLEEP, 11 WAKING
//   asleep              : high in ASLEEP only
//   hb_pulse            : one-clk heartbeat pulse
module mood_engine
  import mood_pkg::*;
#(
  parameter int                    NUM_CH       = 3,
  parameter int                    W            = 7,
  parameter logic [NUM_CH*W-1:0]   DEFAULT_VALS = {7'd64, 7'd0, 7'd96},
  parameter int                    ENERGY_CH    = 0,
  parameter int                    STRESS_CH    = 1,
  parameter int                    SLEEP_HOLD   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [NUM_CH-1:0]         inc_req,
  input  logic [NUM_CH-1:0]         dec_req,
  input  logic                      load,
  input  logic [$clog2(NUM_CH)-1:0] load_ch,
  input  logic [W-1:0]              load_val,
`ifdef MOOD_WAKE_EN
  input  logic                      wake_req,
`endif
  output logic [NUM_CH*W-1:0]       level,
  output logic [2*NUM_CH-1:0]       level_class,
  output logic [1:0]                sleep_state,
  output logic                      asleep,
  output logic                      hb_pulse
);

  localparam int LCH_W  = $clog2(NUM_CH);
  localparam int HOLD_W = $clog2(SLEEP_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLEEP_HOLD - 1);

  sleep_state_t      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        hb_cnt;
  logic [2:0]        hb_m1;
  logic [NUM_CH-1:0] fsm_inc, fsm_dec;
  logic [1:0]        e_cls, s_cls;
  logic              wake;

`ifdef MOOD_WAKE_EN
  assign wake = wake_req;
`else
  assign wake = 1'b0;
`endif

  assign e_cls = level_class[2*ENERGY_CH +: 2];
  assign s_cls = level_class[2*STRESS_CH +: 2];

  // FSM drive contributions, applied on the same tick the state is evaluated
  always_comb begin
    fsm_inc = '0;
    fsm_dec = '0;
    case (state)
      AWAKE, DROWSY: fsm_dec[ENERGY_CH] = 1'b1;
      ASLEEP: begin
        fsm_inc[ENERGY_CH] = 1'b1;
        fsm_dec[STRESS_CH] = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p0: channel level registers
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [LCH_W-1:0] IDX = LCH_W'(i);
    mood_channel #(
      .W          (W),
      .DEFAULT_VAL(DEFAULT_VALS[i*W +: W])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .inc        (inc_req[i] | fsm_inc[i]),
      .dec        (dec_req[i] | fsm_dec[i]),
      .load       (load && (load_ch == IDX)),
      .load_val   (load_val),
      .level      (level[i*W +: W]),
      .level_class(level_class[2*i +: 2])
    );
  end

  // Stage p0: sleep controller (classes seen here are the pre-update ones)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= AWAKE;
      hold_cnt <= '0;
      asleep   <= 1'b0;
    end else if (tick) begin
      case (state)
        AWAKE: begin
          if (e_cls == CLS_LOW) begin
            state    <= DROWSY;
            hold_cnt <= '0;
          end
        end
        DROWSY: begin
          if (wake || (e_cls != CLS_LOW) || (s_cls >= CLS_HIGH)) begin
            state    <= AWAKE;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ASLEEP;
            asleep   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ASLEEP: begin
          if (wake || (e_cls == CLS_MAX) || (s_cls == CLS_MAX)) begin
            state  <= WAKING;
            asleep <= 1'b0;
          end
        end
        WAKING: state <= AWAKE;
        default: state <= AWAKE;
      endcase
    end
  end

  assign sleep_state = state;

  // Stage p0: heartbeat; a shorter period mid-count fires on the next tick
  assign hb_m1 = hb_period_m1(s_cls, state == ASLEEP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_cnt   <= '0;
      hb_pulse <= 1'b0;
    end else if (tick) begin
      if (hb_cnt >= hb_m1) begin
        hb_cnt   <= '0;
        hb_pulse <= 1'b1;
      end else begin
        hb_cnt   <= hb_cnt + 3'd1;
        hb_pulse <= 1'b0;
      end
    end else begin
      hb_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mood_engine.sv
module tb_mood_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [2:0]  inc_req, dec_req;
  logic        load;
  logic [1:0]  load_ch;
  logic [6:0]  load_val;
  logic        wake_req;
  logic [20:0] level;
  logic [5:0]  level_class;
  logic [1:0]  sleep_state;
  logic        asleep;
  logic        hb_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mood_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .inc_req    (inc_req),
    .dec_req    (dec_req),
    .load       (load),
    .load_ch    (load_ch),
    .load_val   (load_val),
`ifdef MOOD_WAKE_EN
    .wake_req   (wake_req),
`endif
    .level      (level),
    .level_class(level_class),
    .sleep_state(sleep_state),
    .asleep     (asleep),
    .hb_pulse   (hb_pulse)
  );

  typedef struct packed {
    logic       ld;
    logic [1:0] ld_ch;
    logic [6:0] ld_val;
    logic       tk;
    logic [2:0] inc;
    logic [2:0] dec;
    logic [6:0] e;
    logic [6:0] s;
    logic [6:0] c2;
    logic [1:0] st;
    logic       hb;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick = 0; inc_req = 0; dec_req = 0; load = 0; load_ch = 0; load_val = 0;
    wake_req = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic tick1();
    tick = 1;
    cyc();
    tick = 0;
  endtask

  initial begin
    int pulses;
    logic [6:0] e, s, c2;

    vt[0]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b010, 7'd95, 7'd0,   7'd64,  2'd0, 1'b0};
    vt[1]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b010, 7'd94, 7'd0,   7'd64,  2'd0, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b010, 7'd93, 7'd0,   7'd64,  2'd0, 1'b0};
    vt[3]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b010, 7'd92, 7'd0,   7'd64,  2'd0, 1'b0};
    vt[4]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b010, 7'd91, 7'd0,   7'd64,  2'd0, 1'b0};
    vt[5]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b100, 3'b100, 7'd90, 7'd0,   7'd64,  2'd0, 1'b0};
    vt[6]  = '{1'b1, 2'd2, 7'd10,  1'b0, 3'b000, 3'b000, 7'd90, 7'd0,   7'd10,  2'd0, 1'b0};
    vt[7]  = '{1'b1, 2'd2, 7'd127, 1'b0, 3'b000, 3'b000, 7'd90, 7'd0,   7'd127, 2'd0, 1'b0};
    vt[8]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b100, 3'b000, 7'd89, 7'd0,   7'd127, 2'd0, 1'b0};
    vt[9]  = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b000, 7'd88, 7'd0,   7'd127, 2'd0, 1'b1};
    vt[10] = '{1'b0, 2'd0, 7'd0,   1'b0, 3'b000, 3'b000, 7'd88, 7'd0,   7'd127, 2'd0, 1'b0};
    vt[11] = '{1'b1, 2'd3, 7'd5,   1'b0, 3'b000, 3'b000, 7'd88, 7'd0,   7'd127, 2'd0, 1'b0};
    vt[12] = '{1'b1, 2'd1, 7'd100, 1'b1, 3'b000, 3'b010, 7'd87, 7'd100, 7'd127, 2'd0, 1'b0};
    vt[13] = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b000, 7'd86, 7'd100, 7'd127, 2'd0, 1'b1};
    vt[14] = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b000, 7'd85, 7'd100, 7'd127, 2'd0, 1'b1};
    vt[15] = '{1'b1, 2'd0, 7'd0,   1'b1, 3'b001, 3'b000, 7'd0,  7'd100, 7'd127, 2'd0, 1'b1};
    vt[16] = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b001, 3'b000, 7'd0,  7'd100, 7'd127, 2'd1, 1'b1};
    vt[17] = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b000, 7'd0,  7'd100, 7'd127, 2'd0, 1'b1};
    vt[18] = '{1'b0, 2'd0, 7'd0,   1'b1, 3'b000, 3'b000, 7'd0,  7'd100, 7'd127, 2'd1, 1'b1};

    rst_n = 0;
    do_reset();
    chk("rst_level",  int'(level),       int'({7'd64, 7'd0, 7'd96}));
    chk("rst_class",  int'(level_class), int'(6'b10_00_11));
    chk("rst_state",  int'(sleep_state), 0);
    chk("rst_hb",     int'(hb_pulse),    0);
    chk("rst_asleep", int'(asleep),      0);

    // Table: saturation, inc+dec hold, loads, heartbeat, FSM bounce
    for (int i = 0; i < 19; i++) begin
      load = vt[i].ld; load_ch = vt[i].ld_ch; load_val = vt[i].ld_val;
      tick = vt[i].tk; inc_req = vt[i].inc; dec_req = vt[i].dec;
      cyc();
      idle();
      e = vt[i].e; s = vt[i].s; c2 = vt[i].c2;
      chk($sformatf("v%0d_energy", i), int'(level[6:0]),   int'(e));
      chk($sformatf("v%0d_stress", i), int'(level[13:7]),  int'(s));
      chk($sformatf("v%0d_ch2", i),    int'(level[20:14]), int'(c2));
      chk($sformatf("v%0d_class", i),  int'(level_class),  int'({c2[6:5], s[6:5], e[6:5]}));
      chk($sformatf("v%0d_state", i),  int'(sleep_state),  int'(vt[i].st));
      chk($sformatf("v%0d_hb", i),     int'(hb_pulse),     int'(vt[i].hb));
    end

    // Free-running sleep cycle from reset
    do_reset();
    pulses = 0;
    for (int t = 1; t <= 64; t++) begin
      tick1();
      if (hb_pulse) pulses++;
    end
    chk("hb_pulses_64", pulses, 8);
    tick1();
    chk("t65_energy", int'(level[6:0]), 31);
    chk("t65_state",  int'(sleep_state), 0);
    tick1();
    chk("t66_state",  int'(sleep_state), 1);
    chk("t66_energy", int'(level[6:0]), 30);
    for (int t = 67; t <= 69; t++) tick1();
    chk("t69_state",  int'(sleep_state), 1);
    chk("t69_asleep", int'(asleep), 0);
    tick1();
    chk("t70_state",  int'(sleep_state), 2);
    chk("t70_asleep", int'(asleep), 1);
    chk("t70_energy", int'(level[6:0]), 26);
    for (int t = 71; t <= 140; t++) tick1();
    chk("t140_energy", int'(level[6:0]), 96);
    chk("t140_state",  int'(sleep_state), 2);
    tick1();
    chk("t141_state",  int'(sleep_state), 3);
    chk("t141_asleep", int'(asleep), 0);
    chk("t141_energy", int'(level[6:0]), 97);
    tick1();
    chk("t142_state",  int'(sleep_state), 0);
    chk("t142_energy", int'(level[6:0]), 97);

    // Heartbeat period shrink mid-count
    do_reset();
    for (int t = 0; t < 5; t++) begin
      tick1();
      chk("hb_pre", int'(hb_pulse), 0);
    end
    load = 1; load_ch = 1; load_val = 7'd70;
    cyc();
    idle();
    chk("ld70_stress", int'(level[13:7]), 70);
    tick1();
    chk("hb_shrink_1", int'(hb_pulse), 1);
    tick1();
    chk("hb_shrink_2", int'(hb_pulse), 0);
    tick1();
    chk("hb_shrink_3", int'(hb_pulse), 1);

    // Reset beats a simultaneous load and tick
    rst_n = 0; tick = 1; load = 1; load_ch = 2; load_val = 7'd5; inc_req = 3'b111;
    cyc();
    idle();
    rst_n = 1;
    chk("rst_mid_level", int'(level), int'({7'd64, 7'd0, 7'd96}));
    chk("rst_mid_hb",    int'(hb_pulse), 0);

`ifdef MOOD_WAKE_EN
    do_reset();
    load = 1; load_ch = 0; load_val = 7'd0;
    cyc();
    idle();
    tick1();
    chk("wk_drowsy", int'(sleep_state), 1);
    wake_req = 1;
    tick1();
    wake_req = 0;
    chk("wk_drowsy_to_awake", int'(sleep_state), 0);
    tick1();
    for (int t = 0; t < 3; t++) tick1();
    chk("wk_drowsy_held", int'(sleep_state), 1);
    wake_req = 1;
    tick1();
    wake_req = 0;
    chk("wk_awake_again", int'(sleep_state), 0);
    tick1();
    for (int t = 0; t < 3; t++) tick1();
    chk("wk_hold_cleared", int'(sleep_state), 1);
    tick1();
    chk("wk_asleep", int'(sleep_state), 2);
    wake_req = 1;
    tick1();
    wake_req = 0;
    chk("wk_asleep_to_waking", int'(sleep_state), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
